// File: rtl/rename_reg_file.sv
// rtl/rename_reg_file.sv - architectural register file with ROB-tag renaming and two combinational read ports
// Optional feature: define RF_COMMIT_BYPASS_EN to forward a same-cycle matching commit onto the read ports.
module rename_reg_file (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rename_valid,
    input  logic [3:0]  rename_pos,
    input  logic [4:0]  rename_rd,
    input  logic        commit_valid,
    input  logic [3:0]  commit_pos,
    input  logic [4:0]  commit_rd,
    input  logic [31:0] commit_val,
    input  logic        flush,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic [3:0]  rs1_tag,
    output logic [3:0]  rs2_tag,
    output logic [31:0] rs1_val,
    output logic [31:0] rs2_val
);

    logic [31:0] r_val  [32];
    logic [3:0]  r_tag  [32];
    logic [31:0] r_busy;

    logic        w_commit_en;
    logic        w_rename_en;
    logic [36:0] w_rs1;
    logic [36:0] w_rs2;

    assign w_commit_en = commit_valid && (commit_rd != 5'd0);
    assign w_rename_en = rename_valid && !flush && (rename_rd != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
            for (int i = 0; i < 32; i++) begin
                r_val[i] <= '0;
                r_tag[i] <= '0;
            end
        end else if (rdy) begin
            if (w_commit_en) begin
                r_val[commit_rd] <= commit_val;
                // A tag mismatch means a younger rename owns the register; leave it busy.
                if (r_busy[commit_rd] && (r_tag[commit_rd] == commit_pos)) begin
                    r_busy[commit_rd] <= 1'b0;
                end
            end
            if (flush) begin
                r_busy <= '0;
                for (int i = 0; i < 32; i++) begin
                    r_tag[i] <= '0;
                end
            end else if (w_rename_en) begin
                // Placed after the commit so a same-register rename overrides the busy clear.
                r_busy[rename_rd] <= 1'b1;
                r_tag[rename_rd]  <= rename_pos;
            end
        end
    end

    // Returns {busy, tag, val} for one source operand.
    function automatic logic [36:0] read_port(input logic [4:0] a);
        logic        b;
        logic [3:0]  t;
        logic [31:0] v;
        b = 1'b0;
        t = 4'd0;
        v = 32'd0;
        if (a != 5'd0) begin
            b = r_busy[a];
            t = r_busy[a] ? r_tag[a] : 4'd0;
            v = r_busy[a] ? 32'd0 : r_val[a];
`ifdef RF_COMMIT_BYPASS_EN
            if (commit_valid && rdy && (commit_rd == a) && r_busy[a] && (r_tag[a] == commit_pos)) begin
                b = 1'b0;
                t = 4'd0;
                v = commit_val;
            end
`endif
        end
        return {b, t, v};
    endfunction

    always_comb begin
        w_rs1 = read_port(rs1_addr);
        w_rs2 = read_port(rs2_addr);
    end

    assign rs1_busy = w_rs1[36];
    assign rs1_tag  = w_rs1[35:32];
    assign rs1_val  = w_rs1[31:0];
    assign rs2_busy = w_rs2[36];
    assign rs2_tag  = w_rs2[35:32];
    assign rs2_val  = w_rs2[31:0];

endmodule

// File: tb/tb_rename_reg_file.sv
// tb/tb_rename_reg_file.sv - directed and randomized checks of rename_reg_file against a reference model
module tb_rename_reg_file;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        rename_valid;
    logic [3:0]  rename_pos;
    logic [4:0]  rename_rd;
    logic        commit_valid;
    logic [3:0]  commit_pos;
    logic [4:0]  commit_rd;
    logic [31:0] commit_val;
    logic        flush;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        rs1_busy, rs2_busy;
    logic [3:0]  rs1_tag, rs2_tag;
    logic [31:0] rs1_val, rs2_val;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_val  [32];
    logic        m_busy [32];
    logic [3:0]  m_tag  [32];

    rename_reg_file dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .rename_valid(rename_valid), .rename_pos(rename_pos), .rename_rd(rename_rd),
        .commit_valid(commit_valid), .commit_pos(commit_pos), .commit_rd(commit_rd),
        .commit_val(commit_val), .flush(flush),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
        .rs1_val(rs1_val), .rs2_val(rs2_val)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) begin
            m_val[i]  = '0;
            m_busy[i] = 1'b0;
            m_tag[i]  = '0;
        end
    endfunction

    function automatic void model_read(input logic [4:0] a, output logic b,
                                       output logic [3:0] t, output logic [31:0] v);
        b = (a != 0) && m_busy[a];
        t = b ? m_tag[a] : 4'd0;
        v = (b || a == 0) ? 32'd0 : m_val[a];
`ifdef RF_COMMIT_BYPASS_EN
        if (commit_valid && rdy && commit_rd == a && a != 0 && m_busy[a] && m_tag[a] == commit_pos) begin
            b = 1'b0;
            t = 4'd0;
            v = commit_val;
        end
`endif
    endfunction

    function automatic void model_edge();
        if (rst) begin
            model_clear();
        end else if (rdy) begin
            if (commit_valid && commit_rd != 0) begin
                m_val[commit_rd] = commit_val;
                if (m_busy[commit_rd] && m_tag[commit_rd] == commit_pos) m_busy[commit_rd] = 1'b0;
            end
            if (flush) begin
                for (int i = 0; i < 32; i++) begin
                    m_busy[i] = 1'b0;
                    m_tag[i]  = '0;
                end
            end else if (rename_valid && rename_rd != 0) begin
                m_busy[rename_rd] = 1'b1;
                m_tag[rename_rd]  = rename_pos;
            end
        end
    endfunction

    task automatic check_ports();
        logic b; logic [3:0] t; logic [31:0] v;
        model_read(rs1_addr, b, t, v);
        chk("rs1_busy", 32'(rs1_busy), 32'(b));
        chk("rs1_tag",  32'(rs1_tag),  32'(t));
        chk("rs1_val",  rs1_val, v);
        model_read(rs2_addr, b, t, v);
        chk("rs2_busy", 32'(rs2_busy), 32'(b));
        chk("rs2_tag",  32'(rs2_tag),  32'(t));
        chk("rs2_val",  rs2_val, v);
    endtask

    task automatic idle();
        rst = 0; rdy = 1; rename_valid = 0; rename_pos = 0; rename_rd = 0;
        commit_valid = 0; commit_pos = 0; commit_rd = 0; commit_val = 0; flush = 0;
    endtask

    // Inputs are applied while clk is low; reads are checked before the rising edge.
    task automatic step();
        #1;
        check_ports();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_rename(input logic [4:0] rd, input logic [3:0] pos);
        idle(); rename_valid = 1; rename_rd = rd; rename_pos = pos; step();
    endtask

    task automatic do_commit(input logic [4:0] rd, input logic [3:0] pos, input logic [31:0] val);
        idle(); commit_valid = 1; commit_rd = rd; commit_pos = pos; commit_val = val; step();
    endtask

    task automatic expect_rd(input string name, input logic [4:0] a, input logic b,
                             input logic [3:0] t, input logic [31:0] v);
        idle(); rs1_addr = a; rs2_addr = a; #1;
        chk({name, ".busy1"}, 32'(rs1_busy), 32'(b));
        chk({name, ".tag1"},  32'(rs1_tag),  32'(t));
        chk({name, ".val1"},  rs1_val, v);
        chk({name, ".busy2"}, 32'(rs2_busy), 32'(b));
        chk({name, ".val2"},  rs2_val, v);
    endtask

    initial begin
        model_clear();
        idle(); rs1_addr = 0; rs2_addr = 0;
        rst = 1; rdy = 0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        model_clear();
        idle();

        expect_rd("reset_x5", 5'd5, 1'b0, 4'd0, 32'd0);
        expect_rd("reset_x0", 5'd0, 1'b0, 4'd0, 32'd0);

        do_rename(5'd5, 4'd3);
        expect_rd("ren_x5", 5'd5, 1'b1, 4'd3, 32'd0);
        do_commit(5'd5, 4'd3, 32'hDEADBEEF);
        expect_rd("com_x5", 5'd5, 1'b0, 4'd0, 32'hDEADBEEF);

        do_rename(5'd7, 4'd2);
        do_rename(5'd7, 4'd9);
        do_commit(5'd7, 4'd2, 32'h11);
        expect_rd("stale_x7", 5'd7, 1'b1, 4'd9, 32'd0);
        do_commit(5'd7, 4'd9, 32'h22);
        expect_rd("final_x7", 5'd7, 1'b0, 4'd0, 32'h22);

        do_rename(5'd3, 4'd4);
        do_rename(5'd4, 4'd5);
        idle(); flush = 1; rename_valid = 1; rename_rd = 6; rename_pos = 6;
        commit_valid = 1; commit_rd = 3; commit_pos = 4; commit_val = 32'h55; step();
        expect_rd("flush_x3", 5'd3, 1'b0, 4'd0, 32'h55);
        expect_rd("flush_x4", 5'd4, 1'b0, 4'd0, 32'd0);
        expect_rd("flush_x6", 5'd6, 1'b0, 4'd0, 32'd0);

        do_rename(5'd8, 4'd1);
        idle(); commit_valid = 1; commit_rd = 8; commit_pos = 1; commit_val = 32'hA;
        rename_valid = 1; rename_rd = 8; rename_pos = 12; step();
        expect_rd("same_x8", 5'd8, 1'b1, 4'd12, 32'd0);
        do_rename(5'd0, 4'd4);
        do_commit(5'd0, 4'd0, 32'hFFFF_FFFF);
        expect_rd("x0_hard", 5'd0, 1'b0, 4'd0, 32'd0);

        do_rename(5'd9, 4'd6);
        idle(); commit_valid = 1; commit_rd = 9; commit_pos = 6; commit_val = 32'h1234;
        rs1_addr = 9; rs2_addr = 9; #1;
`ifdef RF_COMMIT_BYPASS_EN
        chk("byp_busy", 32'(rs1_busy), 32'd0);
        chk("byp_val",  rs1_val, 32'h1234);
`else
        chk("nobyp_busy", 32'(rs1_busy), 32'd1);
        chk("nobyp_tag",  32'(rs1_tag),  32'd6);
`endif
        step();
        expect_rd("post_x9", 5'd9, 1'b0, 4'd0, 32'h1234);

        // rdy low must freeze state even with every operation requested.
        do_rename(5'd10, 4'd7);
        idle(); rdy = 0; flush = 1; commit_valid = 1; commit_rd = 10; commit_pos = 7;
        commit_val = 32'h77; step();
        expect_rd("hold_x10", 5'd10, 1'b1, 4'd7, 32'd0);

        for (int n = 0; n < 400; n++) begin
            idle();
            rdy          = ($urandom_range(0, 7) != 0);
            rst          = ($urandom_range(0, 199) == 0);
            flush        = ($urandom_range(0, 15) == 0);
            rename_valid = $urandom_range(0, 1);
            rename_rd    = 5'($urandom_range(0, 7));
            rename_pos   = 4'($urandom);
            commit_valid = $urandom_range(0, 1);
            commit_rd    = 5'($urandom_range(0, 7));
            commit_pos   = ($urandom_range(0, 3) != 0) ? m_tag[commit_rd] : 4'($urandom);
            commit_val   = $urandom;
            rs1_addr     = ($urandom_range(0, 1) != 0) ? commit_rd : 5'($urandom_range(0, 7));
            rs2_addr     = 5'($urandom_range(0, 7));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rename_reg_file.md
# rename_reg_file

Architectural register file with ROB-tag renaming for the out-of-order RISC-V core. It receives the rename and commit streams that the reorder buffer issues, and holds 32 × 32-bit values plus a busy bit and 4-bit ROB tag per register. It serves two combinational source-operand lookups to the decoder each cycle. A branch-mispredict flush drops all in-flight renames.

## Interface
Parameters:
- None. The design has 32 registers, 32-bit data and 16 ROB entries (4-bit tag), all fixed.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- rdy  in  1  clock enable; state holds when low
- rename_valid  in  1  decoder issued an instruction with destination rename_rd
- rename_pos  in  4  ROB slot allocated to that instruction
- rename_rd  in  5  destination register
- commit_valid  in  1  ROB retired an instruction that writes a register
- commit_pos  in  4  ROB slot being retired
- commit_rd  in  5  destination register of retired instruction
- commit_val  in  32  result value
- flush  in  1  mispredict; discard all renames
- rs1_addr, rs2_addr  in  5  source register indices from decoder
- rs1_busy, rs2_busy  out  1  source waits on an in-flight ROB entry
- rs1_tag, rs2_tag  out  4  ROB slot producing the source; 0 when not busy
- rs1_val, rs2_val  out  32  committed register value; 0 when busy

## Operation
- State per register i: val[i] (32 bits), busy[i], tag[i] (4 bits).
- Reset (rst=1 at an edge, regardless of rdy): all val, busy and tag cleared. Read outputs follow state, so all outputs are 0 after reset.
- Register x0 is hardwired: reads always return busy=0, tag=0, val=0. Renames and commits to x0 are ignored.
- Commit, when commit_valid, rdy and commit_rd≠0:
  - val[commit_rd] ← commit_val, unconditionally.
  - busy[commit_rd] is cleared only if busy=1 and tag[commit_rd]==commit_pos. A tag mismatch means a younger rename exists, so busy and tag are left unchanged.
- Rename, when rename_valid, rdy, !flush and rename_rd≠0: busy[rename_rd] ← 1 and tag[rename_rd] ← rename_pos.
- Same register renamed and committed in one cycle: the value is written and the rename wins, so busy=1 and tag=rename_pos.
- Flush, when flush and rdy:
  - All busy bits and tags are cleared.
  - A commit in the same cycle still writes its value.
  - A rename in the same cycle is dropped.
- Reads are combinational from the current state:
  - busy=busy[a], tag=busy?tag[a]:0, val=busy?0:val[a].
  - A rename in the same cycle never affects that cycle's reads. An instruction reading its own rd therefore sees the old mapping.
- rdy low: no state change. Reads remain valid.

## Timing
- Write latency: commit, rename and flush take effect at the edge and are visible on reads the following cycle.
- Read latency: zero (combinational), except the optional bypass below.
- No handshakes. All inputs are qualified by their valid bit and rdy. The ROB guarantees at most one rename and one commit per cycle.

## Configuration
- RF_COMMIT_BYPASS_EN defined:
  - Reads forward the same-cycle commit.
  - Forwarding condition: commit_valid && rdy && commit_rd==rs_addr && commit_rd≠0 && busy[rs_addr] && tag[rs_addr]==commit_pos.
  - When the condition holds, outputs are busy=0, tag=0, val=commit_val.
  - The same applies to both read ports.
- Not defined: reads reflect registered state only. A value committed in cycle N is visible in cycle N+1.

## Test plan
- Reset, then read x5 and x0 → busy=0, tag=0, val=0 on both ports.
- Rename x5 to pos 3. Next cycle read x5 → busy=1, tag=3, val=0. Commit x5/pos 3/0xDEADBEEF. Next cycle → busy=0, val=0xDEADBEEF.
- Rename x7 to pos 2, then rename x7 to pos 9. Commit x7/pos 2/0x11 → busy=1, tag=9, val reads 0. Commit x7/pos 9/0x22 → busy=0, val=0x22.
- Rename x3 to pos 4 and x4 to pos 5. Assert flush while renaming x6 to pos 6 and committing x3/pos 4/0x55 → next cycle x3 val=0x55 busy=0, x4 busy=0, x6 busy=0.
- Same cycle: commit x8/pos 1/0xA and rename x8 to pos 12 (x8 previously tag 1) → next cycle busy=1, tag=12. Rename x0 to pos 4 → x0 still reads busy=0, val=0.
- With RF_COMMIT_BYPASS_EN: x9 busy with tag 6, commit x9/pos 6/0x1234, rs1_addr=9 in the same cycle → rs1_busy=0, rs1_val=0x1234 combinationally. Without the macro → busy=1 that cycle, 0x1234 the next.
